// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: bank encoding, register geometry,
// the result record carried through the load buffer, and a register-decode helper.
package wb_arbiter_pkg;

    localparam int REG_W    = 48;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_D = 1'b1;

    // A0 is a hardwired register: never written and never marked busy.
    localparam logic [NUM_REGS-1:0] A_WRITABLE = 8'hFE;

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// Load-result buffer: synchronous FIFO with wrap-around pointers, occupancy-derived
// full/empty flags and an asynchronous read of the head so it can commit immediately.
module wb_ld_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t wr_data,
    output wb_req_t rd_data,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        // A full FIFO may still take a push when the head leaves in the same cycle.
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the unstallable ALU result stream and the buffered load
// stream onto the A/D register-file write ports and tracks pending writes per register.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  logic                alu_bank,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [REG_W-1:0]    alu_data,
    input  logic                ld_valid,
    input  logic                ld_bank,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [REG_W-1:0]    ld_data,
    output logic                ld_ready,
    input  logic                iss_valid,
    input  logic                iss_bank,
    input  logic [ADDR_W-1:0]   iss_addr,
    output logic                a_we,
    output logic [ADDR_W-1:0]   a_waddr,
    output logic [REG_W-1:0]    a_wdata,
    output logic                d_we,
    output logic [ADDR_W-1:0]   d_waddr,
    output logic [REG_W-1:0]    d_wdata,
    output logic [NUM_REGS-1:0] busy_a,
    output logic [NUM_REGS-1:0] busy_d
);

    wb_req_t alu_req, ld_req, fifo_head, cand;
    wb_req_t sel [2];
    logic    sel_valid [2];
    logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic    ld_accept, cand_valid, cand_commit;

    logic                init_q, init_d;
    logic                a_we_q, a_we_d, d_we_q, d_we_d;
    logic [ADDR_W-1:0]   a_waddr_q, a_waddr_d, d_waddr_q, d_waddr_d;
    logic [REG_W-1:0]    a_wdata_q, a_wdata_d, d_wdata_q, d_wdata_d;
    logic [NUM_REGS-1:0] busy_a_q, busy_a_d, busy_d_q, busy_d_d;
    logic [NUM_REGS-1:0] set_a, set_d, clr_a, clr_d;

    // init_q keeps ld_ready low until the first edge after reset release.
    assign ld_ready = init_q && !fifo_full;
    assign init_d   = 1'b1;

    wb_ld_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (ld_req),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The load candidate is the FIFO head, or the incoming load bypassing an empty
    // FIFO; it yields only to an ALU result aimed at the same bank.
    always_comb begin
        alu_req     = '{bank: alu_bank, addr: alu_addr, data: alu_data};
        ld_req      = '{bank: ld_bank,  addr: ld_addr,  data: ld_data};
        ld_accept   = ld_valid && ld_ready;
        cand        = fifo_empty ? ld_req : fifo_head;
        cand_valid  = !fifo_empty || ld_accept;
        cand_commit = cand_valid && !(alu_valid && (alu_bank == cand.bank));
        fifo_pop    = !fifo_empty && cand_commit;
        fifo_push   = ld_accept && !(fifo_empty && cand_commit);
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            sel_valid[b] = 1'b0;
            sel[b]       = cand;
            if (alu_valid && (alu_bank == 1'(b))) begin
                sel_valid[b] = 1'b1;
                sel[b]       = alu_req;
            end else if (cand_commit && (cand.bank == 1'(b))) begin
                sel_valid[b] = 1'b1;
                sel[b]       = cand;
            end
        end
    end

    always_comb begin
        a_we_d    = sel_valid[BANK_A] && (sel[BANK_A].addr != '0);
        a_waddr_d = sel_valid[BANK_A] ? sel[BANK_A].addr : a_waddr_q;
        a_wdata_d = sel_valid[BANK_A] ? sel[BANK_A].data : a_wdata_q;
        d_we_d    = sel_valid[BANK_D];
        d_waddr_d = sel_valid[BANK_D] ? sel[BANK_D].addr : d_waddr_q;
        d_wdata_d = sel_valid[BANK_D] ? sel[BANK_D].data : d_wdata_q;
    end

    always_comb begin
        set_a = (iss_valid && (iss_bank == BANK_A)) ? (addr_onehot(iss_addr) & A_WRITABLE) : '0;
        set_d = (iss_valid && (iss_bank == BANK_D)) ? addr_onehot(iss_addr) : '0;
        clr_a = sel_valid[BANK_A] ? addr_onehot(sel[BANK_A].addr) : '0;
        clr_d = sel_valid[BANK_D] ? addr_onehot(sel[BANK_D].addr) : '0;
    end

    // A new reservation wins over a commit to the same register in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            assign busy_a_d[gi] = set_a[gi] | (busy_a_q[gi] & ~clr_a[gi]);
            assign busy_d_d[gi] = set_d[gi] | (busy_d_q[gi] & ~clr_d[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            a_we_q    <= 1'b0;
            a_waddr_q <= '0;
            a_wdata_q <= '0;
            d_we_q    <= 1'b0;
            d_waddr_q <= '0;
            d_wdata_q <= '0;
            busy_a_q  <= '0;
            busy_d_q  <= '0;
        end else begin
            init_q    <= init_d;
            a_we_q    <= a_we_d;
            a_waddr_q <= a_waddr_d;
            a_wdata_q <= a_wdata_d;
            d_we_q    <= d_we_d;
            d_waddr_q <= d_waddr_d;
            d_wdata_q <= d_wdata_d;
            busy_a_q  <= busy_a_d;
            busy_d_q  <= busy_d_d;
        end
    end

    assign a_we    = a_we_q;
    assign a_waddr = a_waddr_q;
    assign a_wdata = a_wdata_q;
    assign d_we    = d_we_q;
    assign d_waddr = d_waddr_q;
    assign d_wdata = d_wdata_q;
    assign busy_a  = busy_a_q;
    assign busy_d  = busy_d_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued per bank
// with the cycle they must appear in, and matched whenever a write enable fires.
module tb_wb_arbiter;

    logic        clk, rst_n;
    logic        alu_valid, alu_bank;
    logic [2:0]  alu_addr;
    logic [47:0] alu_data;
    logic        ld_valid, ld_bank, ld_ready;
    logic [2:0]  ld_addr;
    logic [47:0] ld_data;
    logic        iss_valid, iss_bank;
    logic [2:0]  iss_addr;
    logic        a_we, d_we;
    logic [2:0]  a_waddr, d_waddr;
    logic [47:0] a_wdata, d_wdata;
    logic [7:0]  busy_a, busy_d;

    typedef struct {
        logic [2:0]  addr;
        logic [47:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_d[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    wb_arbiter #(.LD_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_bank  (alu_bank),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_bank   (ld_bank),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .iss_valid (iss_valid),
        .iss_bank  (iss_bank),
        .iss_addr  (iss_addr),
        .a_we      (a_we),
        .a_waddr   (a_waddr),
        .a_wdata   (a_wdata),
        .d_we      (d_we),
        .d_waddr   (d_waddr),
        .d_wdata   (d_wdata),
        .busy_a    (busy_a),
        .busy_d    (busy_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic drive_alu(input logic bank, input logic [2:0] addr, input logic [47:0] data);
        alu_valid = 1'b1; alu_bank = bank; alu_addr = addr; alu_data = data;
    endtask

    task automatic drive_ld(input logic bank, input logic [2:0] addr, input logic [47:0] data);
        ld_valid = 1'b1; ld_bank = bank; ld_addr = addr; ld_data = data;
    endtask

    task automatic drive_iss(input logic bank, input logic [2:0] addr);
        iss_valid = 1'b1; iss_bank = bank; iss_addr = addr;
    endtask

    task automatic expect_wr(input logic bank, input logic [2:0] addr, input logic [47:0] data,
                             input int lat);
        exp_t e;
        e.addr = addr; e.data = data; e.cyc = cyc + lat;
        if (bank) exp_d.push_back(e);
        else      exp_a.push_back(e);
    endtask

    // Advance one cycle and match any write-port activity against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (a_we) begin
            if (exp_a.size() == 0) chk("a_we_unexpected", a_we, 1'b0);
            else begin
                e = exp_a.pop_front();
                chk("a_waddr", a_waddr, e.addr);
                chk("a_wdata", a_wdata, e.data);
                chk("a_cycle", cyc, e.cyc);
            end
        end
        if (d_we) begin
            if (exp_d.size() == 0) chk("d_we_unexpected", d_we, 1'b0);
            else begin
                e = exp_d.pop_front();
                chk("d_waddr", d_waddr, e.addr);
                chk("d_wdata", d_wdata, e.data);
                chk("d_cycle", cyc, e.cyc);
            end
        end
    endtask

    initial begin
        logic [47:0] ldv [3];
        int          li;
        logic        acc;

        rst_n = 1'b0;
        alu_bank = 1'b0; alu_addr = '0; alu_data = '0;
        ld_bank = 1'b0; ld_addr = '0; ld_data = '0;
        iss_bank = 1'b0; iss_addr = '0;
        idle();

        // Reset state
        repeat (2) step();
        chk("rst_a_we", a_we, 1'b0);
        chk("rst_d_we", d_we, 1'b0);
        chk("rst_a_waddr", a_waddr, 3'd0);
        chk("rst_d_wdata", d_wdata, 48'd0);
        chk("rst_busy_a", busy_a, 8'h00);
        chk("rst_busy_d", busy_d, 8'h00);
        chk("rst_ld_ready", ld_ready, 1'b0);
        rst_n = 1'b1;
        chk("rel_ld_ready_pre", ld_ready, 1'b0);
        step();
        chk("rel_ld_ready_post", ld_ready, 1'b1);

        // Single ALU write with busy set then cleared
        drive_iss(1'b0, 3'd3);
        step();
        idle();
        chk("s1_busy_set", busy_a[3], 1'b1);
        drive_alu(1'b0, 3'd3, 48'h123456789ABC);
        expect_wr(1'b0, 3'd3, 48'h123456789ABC, 1);
        step();
        idle();
        chk("s1_a_we", a_we, 1'b1);
        chk("s1_busy_clr", busy_a[3], 1'b0);
        step();
        chk("s1_we_pulse", a_we, 1'b0);

        // Same-bank ALU and load: load deferred one cycle
        chk("s2_ld_ready", ld_ready, 1'b1);
        drive_alu(1'b1, 3'd2, 48'h0000_0000_D2D2);
        drive_ld(1'b1, 3'd5, 48'h0000_0000_D5D5);
        expect_wr(1'b1, 3'd2, 48'h0000_0000_D2D2, 1);
        expect_wr(1'b1, 3'd5, 48'h0000_0000_D5D5, 2);
        step();
        idle();
        repeat (2) step();
        chk("s2_drained", exp_d.size(), 0);

        // Different-bank ALU and load commit together
        drive_alu(1'b0, 3'd1, 48'hAAAA_0000_0001);
        drive_ld(1'b1, 3'd1, 48'hDDDD_0000_0001);
        expect_wr(1'b0, 3'd1, 48'hAAAA_0000_0001, 1);
        expect_wr(1'b1, 3'd1, 48'hDDDD_0000_0001, 1);
        step();
        idle();
        chk("s3_a_we", a_we, 1'b1);
        chk("s3_d_we", d_we, 1'b1);
        step();

        // Loads back up behind a D-bank ALU stream, then drain in order
        ldv[0] = 48'h1111_0000_0000;
        ldv[1] = 48'h2222_0000_0000;
        ldv[2] = 48'h3333_0000_0000;
        li = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                drive_alu(1'b1, 3'd6, 48'hA000 + 48'(k));
                expect_wr(1'b1, 3'd6, 48'hA000 + 48'(k), 1);
            end else begin
                alu_valid = 1'b0;
            end
            if (k == 5) begin
                expect_wr(1'b1, 3'd0, ldv[0], 1);
                expect_wr(1'b1, 3'd1, ldv[1], 2);
                expect_wr(1'b1, 3'd2, ldv[2], 3);
            end
            if (li < 3) drive_ld(1'b1, 3'(li), ldv[li]);
            else        ld_valid = 1'b0;
            acc = ld_valid && ld_ready;
            if (k == 2) chk("s4_ld_ready_full", ld_ready, 1'b0);
            step();
            if (acc) li++;
        end
        idle();
        chk("s4_all_accepted", li, 3);
        chk("s4_drained", exp_d.size(), 0);

        // Busy set priority, A0 discard, commit alongside a different issue
        drive_iss(1'b0, 3'd4);
        step();
        drive_alu(1'b0, 3'd4, 48'h4444_4444_4444);
        expect_wr(1'b0, 3'd4, 48'h4444_4444_4444, 1);
        step();
        idle();
        chk("s5_set_prio", busy_a[4], 1'b1);
        drive_alu(1'b0, 3'd0, 48'h0BAD_0BAD_0BAD);
        drive_iss(1'b0, 3'd0);
        step();
        idle();
        chk("s5_a0_we", a_we, 1'b0);
        chk("s5_a0_busy", busy_a[0], 1'b0);
        drive_alu(1'b0, 3'd4, 48'h5555_5555_5555);
        expect_wr(1'b0, 3'd4, 48'h5555_5555_5555, 1);
        drive_iss(1'b1, 3'd7);
        step();
        idle();
        chk("s5_busy_a4_clr", busy_a[4], 1'b0);
        chk("s5_busy_d7_set", busy_d[7], 1'b1);
        drive_ld(1'b0, 3'd0, 48'h0BAD_0000_0000);
        step();
        idle();
        chk("s5_ld_a0_we", a_we, 1'b0);
        drive_ld(1'b0, 3'd2, 48'h2020_2020_2020);
        expect_wr(1'b0, 3'd2, 48'h2020_2020_2020, 1);
        step();
        idle();
        chk("s5_ld_a2_we", a_we, 1'b1);

        // Mid-cycle reset with two loads buffered
        drive_alu(1'b1, 3'd3, 48'hC0C0_0000_0001);
        expect_wr(1'b1, 3'd3, 48'hC0C0_0000_0001, 1);
        drive_ld(1'b1, 3'd1, 48'hF1F1_F1F1_F1F1);
        step();
        drive_alu(1'b1, 3'd3, 48'hC0C0_0000_0002);
        expect_wr(1'b1, 3'd3, 48'hC0C0_0000_0002, 1);
        drive_ld(1'b1, 3'd2, 48'hF2F2_F2F2_F2F2);
        chk("s6_ld_ready", ld_ready, 1'b1);
        step();
        idle();
        chk("s6_pre_rst_d_we", d_we, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_d_we", d_we, 1'b0);
        chk("s6_async_d_waddr", d_waddr, 3'd0);
        chk("s6_async_d_wdata", d_wdata, 48'd0);
        chk("s6_async_busy_d", busy_d, 8'h00);
        chk("s6_async_ld_ready", ld_ready, 1'b0);
        #1;
        rst_n = 1'b1;
        chk("s6_rel_ld_ready_pre", ld_ready, 1'b0);
        step();
        chk("s6_rel_ld_ready_post", ld_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s6_no_write", d_we, 1'b0);
        end

        chk("end_exp_a_empty", exp_a.size(), 0);
        chk("end_exp_d_empty", exp_d.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
